// File: rtl/nz_arb_pkg.sv
// Shared types and helpers for the zero-skipping round-robin arbiter.
package nz_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int unsigned SKIP_W_DEF = 16;
    localparam int unsigned POP_W      = 32;

    // Number of set bits; callers zero-extend narrower vectors to POP_W.
    function automatic logic [POP_W-1:0] popcount(input logic [POP_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(POP_W); i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Masked priority encoder: lowest set bit above ptr, else lowest set bit overall.
module rr_priority_encoder #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    pos,
    output logic             valid
);

    logic found_hi;

    // Unmasked pass sets the wrap-around fallback; masked pass overrides it.
    always_comb begin
        pos      = '0;
        valid    = 1'b0;
        found_hi = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i] && !valid) begin
                pos   = IW'(i);
                valid = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i] && (i > int'(ptr)) && !found_hi) begin
                pos      = IW'(i);
                found_hi = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nz_rr_arbiter.sv
// Zero-skipping round-robin arbiter with burst locking, feeding one shared
// nonzero-detect/MAC lane through a single registered output stage.
module nz_rr_arbiter
    import nz_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned SKIP_W    = SKIP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DW-1:0]      req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(N_REQ)-1:0] out_src,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [SKIP_W-1:0]        skip_cnt,
    output logic                     busy
);

    localparam int unsigned IW  = $clog2(N_REQ);
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [BCW-1:0]    beat_q, beat_d;

    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q;
    logic [IW-1:0]     out_src_q;
    logic              out_last_q;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [SKIP_W:0]   skip_sum;
    logic              busy_q;

    logic [N_REQ-1:0]  zero_skip;
    logic [N_REQ-1:0]  elig;
    logic [IW-1:0]     pe_pos;
    logic              pe_valid;
    logic              free;
    logic              fwd;
    logic [IW-1:0]     fwd_idx;
    logic [DW-1:0]     fwd_data;
    logic              fwd_last;

    // Classify each requester's current beat.
    always_comb begin
        zero_skip = '0;
        elig      = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            zero_skip[i] = req_valid[i] && (req_data[i*DW +: DW] == '0) && !req_last[i];
            elig[i]      = req_valid[i] && ((req_data[i*DW +: DW] != '0) || req_last[i]);
        end
    end

    assign free = !out_valid_q || out_ready;

    rr_priority_encoder #(
        .N_REQ (N_REQ)
    ) u_pe (
        .req   (elig),
        .ptr   (ptr_q),
        .pos   (pe_pos),
        .valid (pe_valid)
    );

    // Grant FSM: IDLE arbitrates, LOCK holds the lane for one requester.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        beat_d  = beat_q;
        fwd     = 1'b0;
        fwd_idx = gnt_q;
        case (state_q)
            IDLE: begin
                if (pe_valid && free) begin
                    fwd     = 1'b1;
                    fwd_idx = pe_pos;
                    gnt_d   = pe_pos;
                    beat_d  = BCW'(1);
                    if (req_last[pe_pos] || (MAX_BURST == 1)) begin
                        ptr_d = pe_pos;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (elig[gnt_q] && free) begin
                    fwd    = 1'b1;
                    beat_d = beat_q + BCW'(1);
                    if (req_last[gnt_q] || (beat_q == BCW'(MAX_BURST - 1))) begin
                        ptr_d   = gnt_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = zero_skip;
        if (fwd) begin
            req_ready[fwd_idx] = 1'b1;
        end
    end

    assign fwd_data    = req_data[int'(fwd_idx)*DW +: DW];
    assign fwd_last    = req_last[fwd_idx];
    assign out_valid_d = fwd || (out_valid_q && !out_ready);

    assign skip_sum = {1'b0, skip_q} + (SKIP_W + 1)'(popcount(POP_W'(zero_skip)));
    assign skip_d   = skip_sum[SKIP_W] ? '1 : skip_sum[SKIP_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N_REQ - 1);
            gnt_q       <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
            skip_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            skip_q      <= skip_d;
            busy_q      <= (state_d == LOCK) || out_valid_d;
            if (fwd) begin
                out_data_q <= fwd_data;
                out_src_q  <= fwd_idx;
                out_last_q <= fwd_last;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;
    assign skip_cnt  = skip_q;
    assign busy      = busy_q;

endmodule
